// File: rtl/parity_rx_pkg.sv
// Shared types and line-level constants for the parity frame receiver.
// No logic; no latency.
// No flow control; definitions only.
package parity_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/parity_accum.sv
// Running XOR of the serial data bits of one frame.
// q reflects d one clk after an enabled cycle.
// No backpressure; clr has priority over en.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic d,
    output logic q
);

    // Toggle on every enabled 1 bit; clear at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (clr) begin
            q <= 1'b0;
        end else if (en) begin
            q <= q ^ d;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// Serial start/data/parity/stop receiver feeding a one-entry valid/ready output register.
// Word appears 1 clk after the stop-tick edge.
// Receiver never stalls: completion while the held word is unaccepted drops the new frame and pulses overrun.
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_tick,
    input  logic              rx_in,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    rx_state_t         state;
    rx_state_t         state_nxt;
    logic [CW-1:0]     bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W:0]   sh_next;
    logic              acc;
    logic              acc_clr;
    logic              acc_en;
    logic              perr_q;
    logic              frame_done;
    logic              deliver;

    parity_accum u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (acc_en),
        .d     (rx_in),
        .q     (acc)
    );

    // LSB arrives first, so each new bit enters at the top and moves down.
    assign sh_next = {rx_in, shreg} >> 1;

    // A frame may only load when the output slot is empty or being emptied this cycle.
    assign deliver = frame_done && (!out_valid || out_ready);

    // Receive state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and accumulator control; everything advances only on a tick.
    always_comb begin
        state_nxt  = state;
        acc_clr    = 1'b0;
        acc_en     = 1'b0;
        frame_done = 1'b0;
        if (bit_tick) begin
            case (state)
                IDLE: begin
                    if (rx_in == START_BIT) begin
                        state_nxt = DATA;
                        acc_clr   = 1'b1;
                    end
                end
                DATA: begin
                    acc_en = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = PARITY;
                    end
                end
                PARITY: state_nxt = STOP;
                STOP: begin
                    frame_done = 1'b1;
                    state_nxt  = (rx_in == STOP_BIT) ? IDLE : BREAK;
                end
                // A line held low must return high before a new start bit counts.
                BREAK: begin
                    if (rx_in == LINE_IDLE) begin
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Bit counter, shift register and parity verdict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            perr_q  <= 1'b0;
        end else if (bit_tick) begin
            case (state)
                IDLE: begin
                    if (rx_in == START_BIT) begin
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    shreg   <= sh_next[DATA_W-1:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                PARITY: perr_q <= (acc ^ rx_in) != PARITY_ODD;
                default: ;
            endcase
        end
    end

    // One-entry output register with overrun detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= frame_done && out_valid && !out_ready;
            if (deliver) begin
                out_data   <= shreg;
                parity_err <= perr_q;
                frame_err  <= (rx_in != STOP_BIT);
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
